// File: rtl/yarvi_trace_if.sv
// Commit stream from the yarvi core into the trace buffer, plus the drained record stream.
// The trace buffer takes the slave side; the core/host side takes the master side.
interface yarvi_trace_if #(
    parameter int XLEN = 32,
    parameter int VLEN = 32
);
    logic            me_valid;
    logic [1:0]      me_priv;
    logic [VLEN-1:0] me_pc;
    logic [31:0]     me_insn;
    logic [4:0]      me_wb_rd;
    logic [XLEN-1:0] me_wb_val;
    logic            freeze;

    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_priv;
    logic [VLEN-1:0] out_pc;
    logic [31:0]     out_insn;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_val;

    modport slave (
        input  me_valid, me_priv, me_pc, me_insn, me_wb_rd, me_wb_val, out_ready,
        output freeze, out_valid, out_priv, out_pc, out_insn, out_rd, out_val
    );

    modport master (
        output me_valid, me_priv, me_pc, me_insn, me_wb_rd, me_wb_val, out_ready,
        input  freeze, out_valid, out_priv, out_pc, out_insn, out_rd, out_val
    );
endinterface

// File: rtl/yarvi_trace.sv
// Commit-trace FIFO behind the yarvi writeback stage: records retired instructions,
// drains them over valid/ready and freezes the core before the FIFO can overflow.
module yarvi_trace #(
    parameter int XLEN     = 32,
    parameter int VLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int HEADROOM = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    yarvi_trace_if.slave bus,
    output logic [63:0] instret,
    output logic [15:0] dropped,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] FREEZE_CNT = CW'(DEPTH - HEADROOM);

    typedef struct packed {
        logic [1:0]      priv;
        logic [VLEN-1:0] pc;
        logic [31:0]     insn;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          head;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          freeze_q, freeze_d;
    logic [63:0]   instret_q, instret_d;
    logic [15:0]   dropped_q, dropped_d;
    logic          overflow_q, overflow_d;

    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign wr_rec = '{priv: bus.me_priv, pc: bus.me_pc, insn: bus.me_insn,
                      rd: bus.me_wb_rd, val: bus.me_wb_val};

    always_comb begin
        push_req = bus.me_valid & enable;
        pop      = (count_q != '0) & bus.out_ready;
        // A full FIFO still takes a commit when the head leaves on the same edge.
        push_ok  = push_req & ((count_q != FULL_CNT) | pop);
        drop     = push_req & ~push_ok;

        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end

        // Headroom covers instructions already in flight when the core sees freeze.
        freeze_d = (count_d >= FREEZE_CNT);

        instret_d = instret_q + {63'd0, push_ok};

        dropped_d = dropped_q;
        if (drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            freeze_q   <= 1'b0;
            instret_q  <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            freeze_q   <= freeze_d;
            instret_q  <= instret_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: contents are only visible through count_q.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.out_valid = (count_q != '0);
    assign bus.out_priv  = head.priv;
    assign bus.out_pc    = head.pc;
    assign bus.out_insn  = head.insn;
    assign bus.out_rd    = head.rd;
    assign bus.out_val   = head.val;
    assign bus.freeze    = freeze_q;

    assign instret  = instret_q;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_yarvi_trace.sv
// Bench for yarvi_trace: directed vector table, multi-cycle corner sequences and
// randomized traffic, all checked against a queue-based model of the trace buffer.
module tb_yarvi_trace;
    localparam int XLEN     = 32;
    localparam int VLEN     = 32;
    localparam int DEPTH    = 16;
    localparam int HEADROOM = 4;

    typedef struct packed {
        logic [1:0]  priv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] val;
    } rec_t;

    typedef struct {
        logic        v;
        logic        en;
        logic        rdy;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [63:0] exp_instret;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] instret;
    logic [15:0] dropped;
    logic        overflow;

    yarvi_trace_if #(.XLEN(XLEN), .VLEN(VLEN)) bus ();

    yarvi_trace #(.XLEN(XLEN), .VLEN(VLEN), .DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus.slave),
        .instret  (instret),
        .dropped  (dropped),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;

    rec_t        mq[$];
    logic [63:0] m_instret;
    logic [15:0] m_dropped;
    logic        m_over;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic model_reset();
        mq.delete();
        m_instret = '0;
        m_dropped = '0;
        m_over    = 1'b0;
    endtask

    function automatic rec_t mk(input logic [31:0] pc);
        rec_t r;
        r.priv = 2'($urandom_range(0, 3));
        r.pc   = pc;
        r.insn = $urandom;
        r.rd   = 5'($urandom_range(0, 31));
        r.val  = $urandom;
        return r;
    endfunction

    task automatic drive(input logic v, input rec_t r);
        bus.me_valid  = v;
        bus.me_priv   = r.priv;
        bus.me_pc     = r.pc;
        bus.me_insn   = r.insn;
        bus.me_wb_rd  = r.rd;
        bus.me_wb_val = r.val;
    endtask

    task automatic compare_all(input string tag);
        rec_t h;
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
        check({tag, "_freeze"}, 64'(bus.freeze), 64'(mq.size() >= DEPTH - HEADROOM));
        check({tag, "_instret"}, instret, m_instret);
        check({tag, "_dropped"}, 64'(dropped), 64'(m_dropped));
        check({tag, "_overflow"}, 64'(overflow), 64'(m_over));
        if (mq.size() != 0) begin
            h = mq[0];
            check({tag, "_head_priv"}, 64'(bus.out_priv), 64'(h.priv));
            check({tag, "_head_pc"}, 64'(bus.out_pc), 64'(h.pc));
            check({tag, "_head_insn"}, 64'(bus.out_insn), 64'(h.insn));
            check({tag, "_head_rd"}, 64'(bus.out_rd), 64'(h.rd));
            check({tag, "_head_val"}, 64'(bus.out_val), 64'(h.val));
        end
    endtask

    // One clock: predict from the inputs presented, advance, then compare everything.
    task automatic tick(input string tag);
        logic pop, push, acc;
        rec_t cur, tmp;
        pop  = (mq.size() != 0) && bus.out_ready;
        push = bus.me_valid && enable;
        acc  = push && ((mq.size() < DEPTH) || pop);
        cur  = {bus.me_priv, bus.me_pc, bus.me_insn, bus.me_wb_rd, bus.me_wb_val};
        @(posedge clock);
        #1;
        if (pop) tmp = mq.pop_front();
        if (acc) begin
            mq.push_back(cur);
            m_instret++;
        end else if (push) begin
            if (m_dropped != 16'hFFFF) m_dropped++;
            m_over = 1'b1;
        end
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        drive(1'b0, '0);
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        compare_all("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        rec_t        r;
        logic [31:0] last_pc;
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          n, committed, cycles;
        logic        v, en;

        tbl[0] = '{1, 1, 1, 32'h8000_0000, 32'h0010_0093, 5'd1, 32'd1, 1, 32'h8000_0000, 64'd1};
        tbl[1] = '{0, 1, 1, 32'h0,         32'h0,         5'd0, 32'd0, 0, 32'h0,         64'd1};
        tbl[2] = '{1, 0, 1, 32'h9000_0000, 32'h0000_0013, 5'd2, 32'd7, 0, 32'h0,         64'd1};
        tbl[3] = '{1, 1, 0, 32'h8000_0004, 32'h0020_0113, 5'd2, 32'd2, 1, 32'h8000_0004, 64'd2};
        tbl[4] = '{1, 1, 0, 32'h8000_0008, 32'h0030_0193, 5'd3, 32'd3, 1, 32'h8000_0004, 64'd3};
        tbl[5] = '{0, 1, 1, 32'h0,         32'h0,         5'd0, 32'd0, 1, 32'h8000_0008, 64'd3};
        tbl[6] = '{1, 1, 1, 32'h8000_000c, 32'h0040_0213, 5'd4, 32'd4, 1, 32'h8000_000c, 64'd4};
        tbl[7] = '{0, 1, 1, 32'h0,         32'h0,         5'd0, 32'd0, 0, 32'h0,         64'd4};

        reset = 1'b1;
        enable = 1'b1;
        drive(1'b0, '0);
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_freeze", 64'(bus.freeze), 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_dropped", 64'(dropped), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Directed vectors, starting with the single-commit case.
        for (int i = 0; i < 8; i++) begin
            r = '{priv: 2'd3, pc: tbl[i].pc, insn: tbl[i].insn, rd: tbl[i].rd, val: tbl[i].val};
            drive(tbl[i].v, r);
            enable = tbl[i].en;
            bus.out_ready = tbl[i].rdy;
            tick($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_v));
            if (tbl[i].exp_v) check($sformatf("tbl%0d_pc", i), 64'(bus.out_pc), 64'(tbl[i].exp_pc));
            check($sformatf("tbl%0d_instret", i), instret, tbl[i].exp_instret);
            check($sformatf("tbl%0d_freeze", i), 64'(bus.freeze), 64'd0);
            if (i == 0) begin
                check("single_insn", 64'(bus.out_insn), 64'h0010_0093);
                check("single_rd", 64'(bus.out_rd), 64'd1);
                check("single_val", 64'(bus.out_val), 64'd1);
            end
        end

        // Fill to the freeze threshold, then keep committing past full.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, mk(32'h0000_1000 + 32'(4 * i)));
            tick("fill");
            if (i == 10) check("fill_freeze_11", 64'(bus.freeze), 64'd0);
            if (i == 11) begin
                check("fill_freeze_12", 64'(bus.freeze), 64'd1);
                check("fill_dropped_12", 64'(dropped), 64'd0);
            end
        end
        drive(1'b0, '0);
        check("ovf_dropped", 64'(dropped), 64'd2);
        check("ovf_overflow", 64'(overflow), 64'd1);
        check("ovf_instret", instret, 64'd16);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf_drain%0d_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("ovf_drain%0d_pc", k), 64'(bus.out_pc), 64'(32'h0000_1000 + 32'(4 * k)));
            tick("ovf_drain");
        end
        check("ovf_drained_empty", 64'(bus.out_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with a push and a pop on the same edge.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, mk(32'h0000_2000 + 32'(4 * i)));
            tick("full");
        end
        drive(1'b1, mk(32'h0000_3000));
        bus.out_ready = 1'b1;
        tick("full_pp");
        check("full_pp_dropped", 64'(dropped), 64'd0);
        check("full_pp_freeze", 64'(bus.freeze), 64'd1);
        check("full_pp_head", 64'(bus.out_pc), 64'h2004);
        drive(1'b0, '0);
        n = 0;
        last_pc = '0;
        while (bus.out_valid && n < 40) begin
            last_pc = bus.out_pc;
            n++;
            tick("full_drain");
        end
        check("full_pp_count", 64'(n), 64'd16);
        check("full_pp_last_pc", 64'(last_pc), 64'h3000);

        // Random traffic; commits stall while freeze is high.
        do_reset();
        committed = 0;
        cycles = 0;
        while (committed < 100 && cycles < 5000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 9) != 0);
            v  = !bus.freeze && ($urandom_range(0, 2) != 0);
            if (v && en) begin
                drive(1'b1, mk(32'h0000_4000 + 32'(4 * committed)));
                sent.push_back(32'h0000_4000 + 32'(4 * committed));
                committed++;
            end else begin
                drive(v, mk(32'hdead_0000));
            end
            enable = en;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_pc);
            tick("rand");
            cycles++;
        end
        check("rand_budget", 64'(committed), 64'd100);
        drive(1'b0, '0);
        enable = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.out_valid && n < 40) begin
            got.push_back(bus.out_pc);
            n++;
            tick("rand_drain");
        end
        check("rand_out_count", 64'(got.size()), 64'd100);
        for (int i = 0; i < 100; i++) begin
            if (i < got.size() && i < sent.size())
                check($sformatf("rand_seq%0d", i), 64'(got[i]), 64'(sent[i]));
        end
        check("rand_dropped", 64'(dropped), 64'd0);
        check("rand_instret", instret, 64'd100);

        // Asynchronous reset between edges while five records are queued.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mk(32'h0000_5000 + 32'(4 * i)));
            tick("ar_fill");
        end
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        tick("ar_drain");
        check("ar_pre_instret", instret, 64'd6);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check("ar_freeze", 64'(bus.freeze), 64'd0);
        check("ar_instret", instret, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("ar_idle");
        check("ar_idle_valid", 64'(bus.out_valid), 64'd0);
        check("ar_idle_instret", instret, 64'd0);
        drive(1'b1, mk(32'h0000_6000));
        tick("ar_new");
        drive(1'b0, '0);
        check("ar_new_valid", 64'(bus.out_valid), 64'd1);
        check("ar_new_pc", 64'(bus.out_pc), 64'h6000);
        check("ar_new_instret", instret, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/yarvi_trace.md
Name: yarvi_trace

Overview:
- Commit-trace buffer directly downstream of the yarvi core's ME/writeback outputs.
- Captures each valid retired instruction (priv, pc, insn, rd, value) into a FIFO and drains it over a valid/ready stream to a debug/UART host.
- Drives the core's freeze input to backpressure the pipeline before the FIFO overflows.
- Counts retired instructions and any records dropped on overflow.

Parameters:
- XLEN, 32: width of the writeback value.
- VLEN, 32: width of the PC.
- DEPTH, 16: FIFO entries; must be a power of two, at least 4.
- HEADROOM, 4: free entries remaining when freeze asserts; must satisfy 1 <= HEADROOM < DEPTH.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; when low, commits are neither recorded nor counted.
- me_valid  in  1  retiring instruction valid.
- me_priv  in  2  privilege level of the retiring instruction.
- me_pc  in  VLEN  PC of the retiring instruction.
- me_insn  in  32  instruction word.
- me_wb_rd  in  5  destination register; 0 means no writeback.
- me_wb_val  in  XLEN  writeback value.
- freeze  out  1  stall request to the core; registered.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_priv  out  2  head record field.
- out_pc  out  VLEN  head record field.
- out_insn  out  32  head record field.
- out_rd  out  5  head record field.
- out_val  out  XLEN  head record field.
- instret  out  64  count of recorded commits.
- dropped  out  16  count of commits lost to overflow; saturates at 0xFFFF.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset is asynchronous and active-high. While reset is high: read/write pointers = 0, count = 0, out_valid = 0, freeze = 0, instret = 0, dropped = 0, overflow = 0. out_* data fields are don't-care.
- Push: occurs on a rising edge when me_valid & enable.
  - Accepted if count < DEPTH, or if count == DEPTH and a pop happens the same cycle (simultaneous pop-while-full is accepted; count stays DEPTH).
  - Otherwise the record is dropped: dropped increments (saturating) and overflow is set.
- instret increments once per accepted push. It wraps modulo 2^64.
- Pop: occurs when out_valid & out_ready at a rising edge. The head advances and count decrements, unless a push coincides.
- Latency: a record pushed at edge N is visible on out_* (out_valid = 1 if the FIFO was empty) after edge N. There is no combinational fall-through from me_* to out_*.
- out_valid == (count != 0). Head fields hold stable while out_valid & !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, covering 0..DEPTH.
- freeze is registered: freeze <= (count_next >= DEPTH-HEADROOM), where count_next is the post-update occupancy.
  - It deasserts only when count_next < DEPTH-HEADROOM.
  - HEADROOM absorbs instructions already in flight in the core's pipeline.
- Simultaneous push and pop with count == 0: out_valid is low, so no pop occurs; the push lands and count = 1.
- enable low mid-stream: draining continues; freeze still follows occupancy.
- Reset asserted mid-operation: all contents are discarded immediately (asynchronously); no partial record is emitted.
- overflow and dropped clear only on reset.

Test Plan:
- Single commit: reset, then one cycle with me_valid=1, pc=0x80000000, insn=0x00100093, rd=1, val=1, out_ready=1.
  - Required: after the next edge, out_valid=1 with those exact fields for one cycle, then 0.
  - Required: instret=1, freeze=0.
- Fill and freeze: out_ready=0, 12 consecutive commits with DEPTH=16, HEADROOM=4.
  - Required: freeze rises after the 12th push edge; count=12, no drops.
- Overflow: out_ready=0, 18 consecutive commits ignoring freeze.
  - Required: entries 1-16 retained, dropped=2, overflow=1, instret=16.
  - Required: draining then yields exactly the first 16 pcs in order.
- Full with simultaneous push and pop: count=16, out_ready=1, and a commit in the same cycle.
  - Required: push accepted, count stays 16, dropped unchanged.
  - Required: the new record emerges 16th in order.
- Wrap-around and backpressure: 100 commits with a random out_ready pattern, and the bench honours freeze by stalling commits.
  - Required: the output sequence equals the input sequence, dropped=0, instret=100.
- Async reset mid-drain: assert reset between edges while count=5.
  - Required: out_valid, freeze, and instret read 0 immediately (before the next edge), and remain 0 after release until a new commit.
